// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - shared state encoding and defaults for the step/run controller
package step_ctrl_pkg;

  localparam logic [1:0] ST_STEP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int RUN_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    STATE_STEP = ST_STEP,
    STATE_RUN  = ST_RUN,
    STATE_HALT = ST_HALT
  } state_t;

  // A divide-by-1 prescaler still needs one bit of storage.
  function automatic int prescale_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/run_prescaler.sv
// rtl/run_prescaler.sv - modulo-RUN_DIV counter with clear, enable and terminal-count output
module run_prescaler
  import step_ctrl_pkg::*;
#(
  parameter int RUN_DIV = RUN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = prescale_width(RUN_DIV);
  localparam logic [W-1:0] LAST = W'(RUN_DIV - 1);

  logic [W-1:0] p;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      p <= '0;
    end else if (enable) begin
      p <= (p == LAST) ? '0 : p + 1'b1;
    end
  end

  assign tc = (p == LAST);

endmodule

// File: rtl/step_run_controller.sv
// rtl/step_run_controller.sv - step/run/halt CPU clock-enable generator
// Optional executed-step counter built when STEP_COUNT_EN is defined; otherwise step_count is tied to 0.
module step_run_controller
  import step_ctrl_pkg::*;
#(
  parameter int RUN_DIV = RUN_DIV_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_pulse,
  input  logic             mode_pulse,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  state_t state;
  state_t next_state;
  logic   cpu_en_next;
  logic   tc;
  logic   run_en;
  logic   clear_p;

  // Priority: halt over mode_pulse over step_pulse; any state change suppresses the enable.
  always_comb begin
    next_state  = state;
    cpu_en_next = 1'b0;
    case (state)
      STATE_STEP: begin
        if (halt)            next_state = STATE_HALT;
        else if (mode_pulse) next_state = STATE_RUN;
        else                 cpu_en_next = step_pulse;
      end
      STATE_RUN: begin
        if (halt)            next_state = STATE_HALT;
        else if (mode_pulse) next_state = STATE_STEP;
        else                 cpu_en_next = tc;
      end
      STATE_HALT: next_state = STATE_HALT;
      default:    next_state = STATE_STEP;
    endcase
  end

  // Prescaler only advances while staying in RUN, so every entry starts at p = 0.
  assign run_en  = (state == STATE_RUN);
  assign clear_p = (state != STATE_RUN) || (next_state != STATE_RUN);

  run_prescaler #(.RUN_DIV(RUN_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_p),
    .enable (run_en),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= STATE_STEP;
      cpu_en  <= 1'b0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= next_state;
      cpu_en  <= cpu_en_next;
      running <= (next_state == STATE_RUN);
      halted  <= (next_state == STATE_HALT);
    end
  end

`ifdef STEP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      step_count <= '0;
    end else if (cpu_en) begin
      step_count <= step_count + 1'b1;
    end
  end
`else
  assign step_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/step_run_controller.md
# step_run_controller

Consumes the single-cycle button pulses produced by the push-button conditioning stage and turns them into a CPU clock-enable. Supports single-step mode (one enable per step press), free-run mode (one enable every RUN_DIV cycles) and a terminal halt state requested by the CPU. It sits between the push-button stages and the datapath's global enable, and optionally exposes an executed-step counter for the seven-segment display.

## Interface
- RUN_DIV, 4, cycles per enable in run mode; legal range ≥ 1
- CNT_W, 16, width of step_count
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- step_pulse  in  1  single-cycle step request from the push-button stage
- mode_pulse  in  1  single-cycle run/step toggle from a second push-button stage
- halt  in  1  level from CPU (ebreak/ecall decode); sampled every cycle
- cpu_en  out  1  registered CPU clock-enable
- running  out  1  high while in RUN
- halted  out  1  high while in HALT
- step_count  out  CNT_W  number of cycles with cpu_en high

## Operation
- States: STEP (reset state), RUN, HALT.
- **STEP**
  - step_pulse high → cpu_en high for the next cycle.
  - mode_pulse → RUN. The prescaler is cleared on entry.
- **RUN**
  - Prescaler p counts 0..RUN_DIV-1, then wraps to 0.
  - cpu_en <= (p == RUN_DIV-1).
  - step_pulse is ignored.
  - mode_pulse → STEP, and p is cleared.
- **HALT**
  - cpu_en is held 0. All pulses are ignored.
  - Exit only via reset.
- halt high in STEP or RUN → HALT.
- Priority within a cycle: halt > mode_pulse > step_pulse.
  - halt or mode_pulse in cycle t forces cpu_en = 0 at t+1, even if p was at terminal count or step_pulse was high.
- No internal edge detection. Each cycle with step_pulse high is one request; a level held N cycles yields N enables.
- running = (state == RUN). halted = (state == HALT). Both are registered.
- step_count increments on every cycle in which cpu_en is high. It wraps from 2^CNT_W-1 to 0.
- Reset values: state STEP, p = 0, cpu_en 0, running 0, halted 0, step_count 0.
- Reset mid-operation: reset has priority over all inputs; reset values appear the cycle after reset is sampled.

## Timing
- Step latency: step_pulse at cycle t → cpu_en high at t+1 only.
- Run entry: mode_pulse at t → running = 1 at t+1, p = 0 at t+1.
  - First cpu_en at t+RUN_DIV+1, then one enable every RUN_DIV cycles.
  - With RUN_DIV = 1, cpu_en stays high from t+2.
- Run exit: mode_pulse at t → running = 0 and cpu_en = 0 at t+1.
- Halt: halt at t → halted = 1 and cpu_en = 0 at t+1.
- step_count reflects an enable one cycle after that enable: cpu_en high at t → count updated at t+1.

## Configuration
- STEP_COUNT_EN defined: the step_count register is built as described.
- STEP_COUNT_EN undefined: the counter is not synthesized and step_count is tied to 0. The port list is unchanged, so the display wiring stays identical.

## Structure
- Shared package step_ctrl_pkg:
  - state encoding localparams ST_STEP = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2.
  - default RUN_DIV constant.
- One natural sub-module: run_prescaler. It is the modulo-RUN_DIV counter with clear and enable inputs and a terminal-count output, width $clog2(RUN_DIV) (minimum 1).
- State register, cpu_en register and step counter live in the top.

## Test plan
- Reset, then step_pulse at cycle 5 → cpu_en high only at cycle 6; step_count = 1 at cycle 7; running = 0, halted = 0 throughout.
- RUN_DIV = 4, mode_pulse at cycle 10 → running = 1 at 11; cpu_en at 15, 19, 23; step_pulse at 17 has no effect.
- In RUN with p = 3 at cycle t, mode_pulse at t → cpu_en = 0 at t+1, running = 0. A subsequent step_pulse at t+3 → cpu_en at t+4.
- halt, mode_pulse and step_pulse all high in the same STEP-state cycle → halted = 1 next cycle, no cpu_en. Later pulses ignored; reset returns to STEP with all outputs 0.
- CNT_W = 4 with STEP_COUNT_EN, 17 steps → step_count = 1 (wrap). Without the macro → step_count stays 0 throughout.
- Reset asserted mid-RUN for one cycle → next cycle running = 0, cpu_en = 0, step_count = 0; p restarts from 0 on the next run entry.
